// File: rtl/fl_pkg.sv
// Shared constants for the parallel NOR flash word reader: FSM state codes,
// default board timing and a constant helper for sizing the shared timer.
package fl_pkg;

  localparam logic [2:0] ST_RST_HOLD = 3'd0;
  localparam logic [2:0] ST_RST_WAIT = 3'd1;
  localparam logic [2:0] ST_IDLE     = 3'd2;
  localparam logic [2:0] ST_RD_LO    = 3'd3;
  localparam logic [2:0] ST_RD_HI    = 3'd4;

  // 4 clocks at 50 MHz covers the 70 ns access time with margin.
  localparam int DEF_WAIT_CYCLES = 4;
  localparam int DEF_RST_LOW     = 32;
  localparam int DEF_RST_RECOV   = 16;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/fl_timer.sv
// Loadable down-counter with a zero flag; it saturates at zero until reloaded.
module fl_timer #(
  parameter int                 TW        = 5,
  parameter logic [TW-1:0]      RST_VALUE = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [TW-1:0] load_value,
  output logic          zero
);

  logic [TW-1:0] count;

  // NOTE: sequential state is assigned with <= so every register samples
  // pre-edge values and block ordering never changes behaviour.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= RST_VALUE;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/fl_word_reader.sv
// Read-only byte-mode NOR flash controller: sequences flash power-up reset,
// then serves 16-bit word reads (two byte accesses) over a toggle req/ack.
module fl_word_reader
  import fl_pkg::*;
#(
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
  parameter int RST_LOW     = DEF_RST_LOW,
  parameter int RST_RECOV   = DEF_RST_RECOV
) (
  input  logic        iclk,
  input  logic        ireset_n,
  input  logic [22:0] iaddr,
  input  logic        ireq,
  output logic [15:0] odata,
  output logic        oack,
  output logic        oready,
  output logic [22:0] ofl_addr,
  input  logic [7:0]  ifl_dq,
  output logic        ofl_ce_n,
  output logic        ofl_oe_n,
  output logic        ofl_we_n,
  output logic        ofl_wp_n,
  output logic        ofl_rst_n
);

  localparam int TMAX = max3(RST_LOW, RST_RECOV, WAIT_CYCLES);
  localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

  // Each delay is loaded as N-1 so the state lasts exactly N clocks.
  localparam logic [TW-1:0] LD_RST_LOW   = TW'(RST_LOW - 1);
  localparam logic [TW-1:0] LD_RST_RECOV = TW'(RST_RECOV - 1);
  localparam logic [TW-1:0] LD_WAIT      = TW'(WAIT_CYCLES - 1);

  logic [2:0]    state;
  logic [7:0]    lo_byte;
  logic          pending;
  logic          tmr_zero;
  logic          tmr_load;
  logic [TW-1:0] tmr_value;

  assign pending  = (ireq != oack);
  assign ofl_we_n = 1'b1;
  assign ofl_wp_n = 1'b1;

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    tmr_load  = 1'b0;
    tmr_value = '0;
    case (state)
      ST_RST_HOLD: begin
        tmr_load  = tmr_zero;
        tmr_value = LD_RST_RECOV;
      end
      ST_RST_WAIT: ;
      ST_IDLE: begin
        tmr_load  = pending;
        tmr_value = LD_WAIT;
      end
      ST_RD_LO: begin
        tmr_load  = tmr_zero;
        tmr_value = LD_WAIT;
      end
      ST_RD_HI: ;
      default: begin
        tmr_load  = 1'b1;
        tmr_value = LD_RST_LOW;
      end
    endcase
  end

  fl_timer #(
    .TW        (TW),
    .RST_VALUE (LD_RST_LOW)
  ) u_timer (
    .clk        (iclk),
    .rst_n      (ireset_n),
    .load       (tmr_load),
    .load_value (tmr_value),
    .zero       (tmr_zero)
  );

  always_ff @(posedge iclk or negedge ireset_n) begin
    if (!ireset_n) begin
      state     <= ST_RST_HOLD;
      odata     <= '0;
      oack      <= 1'b0;
      oready    <= 1'b0;
      ofl_addr  <= '0;
      ofl_ce_n  <= 1'b1;
      ofl_oe_n  <= 1'b1;
      ofl_rst_n <= 1'b0;
      lo_byte   <= '0;
    end else begin
      case (state)
        ST_RST_HOLD: begin
          if (tmr_zero) begin
            ofl_rst_n <= 1'b1;
            state     <= ST_RST_WAIT;
          end
        end
        ST_RST_WAIT: begin
          if (tmr_zero) begin
            oready <= 1'b1;
            state  <= ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (pending) begin
            ofl_addr <= {iaddr[22:1], 1'b0};
            ofl_ce_n <= 1'b0;
            ofl_oe_n <= 1'b0;
            state    <= ST_RD_LO;
          end
        end
        ST_RD_LO: begin
          // ce/oe stay low; only the byte select bit moves for the odd byte.
          if (tmr_zero) begin
            lo_byte     <= ifl_dq;
            ofl_addr[0] <= 1'b1;
            state       <= ST_RD_HI;
          end
        end
        ST_RD_HI: begin
          if (tmr_zero) begin
            odata    <= {ifl_dq, lo_byte};
            oack     <= ~oack;
            ofl_ce_n <= 1'b1;
            ofl_oe_n <= 1'b1;
            state    <= ST_IDLE;
          end
        end
        default: begin
          ofl_rst_n <= 1'b0;
          oready    <= 1'b0;
          ofl_ce_n  <= 1'b1;
          ofl_oe_n  <= 1'b1;
          state     <= ST_RST_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fl_word_reader.sv
// Bench for fl_word_reader: behavioural flash model, table vectors, random and
// back-to-back reads, power-up sequencing and reset-abort corner cases.
module tb_fl_word_reader;

  logic        iclk;
  logic        ireset_n;
  logic [22:0] iaddr;
  logic        ireq;
  logic [15:0] odata;
  logic        oack;
  logic        oready;
  logic [22:0] ofl_addr;
  logic [7:0]  ifl_dq;
  logic        ofl_ce_n;
  logic        ofl_oe_n;
  logic        ofl_we_n;
  logic        ofl_wp_n;
  logic        ofl_rst_n;

  int n_vec = 0;
  int n_bad = 0;

  fl_word_reader #(
    .WAIT_CYCLES (4),
    .RST_LOW     (32),
    .RST_RECOV   (16)
  ) dut (
    .iclk      (iclk),
    .ireset_n  (ireset_n),
    .iaddr     (iaddr),
    .ireq      (ireq),
    .odata     (odata),
    .oack      (oack),
    .oready    (oready),
    .ofl_addr  (ofl_addr),
    .ifl_dq    (ifl_dq),
    .ofl_ce_n  (ofl_ce_n),
    .ofl_oe_n  (ofl_oe_n),
    .ofl_we_n  (ofl_we_n),
    .ofl_wp_n  (ofl_wp_n),
    .ofl_rst_n (ofl_rst_n)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  // Flash: byte(a) = a[7:0]^A5, valid once the address has been stable 3 clocks.
  logic [22:0] fl_last_addr = '0;
  int          fl_age       = 0;
  always @(negedge iclk) begin
    if (ofl_addr != fl_last_addr) begin
      fl_last_addr = ofl_addr;
      fl_age       = 0;
    end else if (fl_age < 1000) begin
      fl_age++;
    end
    if (fl_age >= 3 && !ofl_ce_n && !ofl_oe_n) ifl_dq = ofl_addr[7:0] ^ 8'hA5;
    else ifl_dq = 8'hxx;
  end

  function automatic logic [15:0] model_word(input logic [22:0] a);
    logic [7:0] lo;
    logic [7:0] hi;
    lo = {a[7:1], 1'b0} ^ 8'hA5;
    hi = {a[7:1], 1'b1} ^ 8'hA5;
    return {hi, lo};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // One word read from IDLE; lat is clocks from the detect edge to the oack toggle.
  task automatic do_read(input logic [22:0] a, output logic [15:0] d, output int lat,
                         output logic ce_ok, output logic [22:0] a_lo, output logic [22:0] a_hi);
    int edges;
    @(negedge iclk);
    iaddr = a;
    ireq  = ~ireq;
    edges = 0;
    ce_ok = 1'b1;
    a_lo  = '0;
    a_hi  = '0;
    while (oack != ireq && edges < 100) begin
      @(posedge iclk);
      #1;
      edges++;
      if (oack != ireq && (ofl_ce_n || ofl_oe_n)) ce_ok = 1'b0;
      if (edges == 1) a_lo = ofl_addr;
      if (edges == 5) a_hi = ofl_addr;
    end
    lat = edges - 1;
    d   = odata;
  endtask

  // Release reset and watch the power-up sequence; optionally request during RST_HOLD.
  task automatic powerup(input bit pend);
    int rise_k, rdy_k, ce_k, ack_k;
    ireq = 1'b0;
    @(negedge iclk);
    ireset_n = 1'b1;
    rise_k = 0; rdy_k = 0; ce_k = 0; ack_k = 0;
    for (int k = 1; k <= 70; k++) begin
      @(posedge iclk);
      #1;
      if (ofl_rst_n && rise_k == 0) rise_k = k;
      if (oready && rdy_k == 0) rdy_k = k;
      if ((!ofl_ce_n || !ofl_oe_n) && ce_k == 0) ce_k = k;
      if (oack && ack_k == 0) ack_k = k;
      if (pend && k == 5) begin
        iaddr = 23'h000182;
        ireq  = 1'b1;
      end
    end
    check("pwr_rst_rise_clk", rise_k, 32);
    check("pwr_ready_clk", rdy_k, 48);
    if (pend) begin
      // First IDLE cycle detects at clock 49, ack 8 clocks later.
      check("pend_first_access_clk", ce_k, 49);
      check("pend_ack_clk", ack_k, 57);
      check("pend_data", odata, 16'h2627);
    end else begin
      check("pwr_no_access", ce_k, 0);
      check("pwr_no_ack", ack_k, 0);
    end
  endtask

  typedef struct {
    logic [22:0] addr;
    logic [15:0] data;
    logic [22:0] a_lo;
    logic [22:0] a_hi;
  } vec_t;

  initial begin
    vec_t        tbl[4];
    logic [15:0] d;
    int          lat;
    logic        ce_ok;
    logic [22:0] a_lo, a_hi, a;

    tbl[0] = '{23'h000182, 16'h2627, 23'h000182, 23'h000183};
    tbl[1] = '{23'h000001, 16'hA4A5, 23'h000000, 23'h000001};
    tbl[2] = '{23'h7FFFFE, 16'h5A5B, 23'h7FFFFE, 23'h7FFFFF};
    tbl[3] = '{23'h2AAAAB, 16'h0E0F, 23'h2AAAAA, 23'h2AAAAB};

    ireset_n = 1'b0;
    iaddr    = '0;
    ireq     = 1'b0;
    #23;
    check("rst_odata", odata, 16'h0);
    check("rst_oack", oack, 0);
    check("rst_oready", oready, 0);
    check("rst_fl_addr", ofl_addr, 0);
    check("rst_ce_oe", {ofl_ce_n, ofl_oe_n}, 2'b11);
    check("rst_fl_rst_n", ofl_rst_n, 0);
    check("we_wp", {ofl_we_n, ofl_wp_n}, 2'b11);

    powerup(1'b0);

    for (int i = 0; i < 4; i++) begin
      do_read(tbl[i].addr, d, lat, ce_ok, a_lo, a_hi);
      check($sformatf("tbl%0d_data", i), d, tbl[i].data);
      check($sformatf("tbl%0d_lat", i), lat, 8);
      check($sformatf("tbl%0d_ce_low", i), ce_ok, 1);
      check($sformatf("tbl%0d_addr_lo", i), a_lo, tbl[i].a_lo);
      check($sformatf("tbl%0d_addr_hi", i), a_hi, tbl[i].a_hi);
      check($sformatf("tbl%0d_ce_idle", i), {ofl_ce_n, ofl_oe_n}, 2'b11);
    end

    for (int i = 0; i < 24; i++) begin
      a = 23'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge iclk);
      do_read(a, d, lat, ce_ok, a_lo, a_hi);
      check($sformatf("rnd%0d_data", i), d, model_word(a));
      check($sformatf("rnd%0d_lat", i), lat, 8);
      check($sformatf("rnd%0d_addr_lo", i), a_lo, {a[22:1], 1'b0});
    end

    // Hold of odata between handshakes.
    repeat (5) @(negedge iclk);
    check("odata_hold", odata, model_word(a));

    for (int i = 0; i < 256; i++) begin
      a = 23'h7FFE00 + 23'(2 * i);
      do_read(a, d, lat, ce_ok, a_lo, a_hi);
      check($sformatf("b2b%0d_data", i), d, model_word(a));
      check($sformatf("b2b%0d_lat", i), lat, 8);
    end
    check("b2b_last_word", d, 16'h5A5B);

    // Reset asserted while the odd byte is being read.
    @(negedge iclk);
    iaddr = 23'h000400;
    ireq  = ~ireq;
    repeat (6) @(posedge iclk);
    #2;
    ireset_n = 1'b0;
    #1;
    check("abort_ce_oe", {ofl_ce_n, ofl_oe_n}, 2'b11);
    check("abort_oack", oack, 0);
    check("abort_odata", odata, 16'h0);
    check("abort_oready", oready, 0);
    check("abort_fl_rst_n", ofl_rst_n, 0);
    powerup(1'b0);

    // Request raised during RST_HOLD is held and served after power-up.
    @(negedge iclk);
    ireset_n = 1'b0;
    #3;
    powerup(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
